// File: rtl/ps2_keymap_decoder_pkg.sv
// Shared constants for the PS/2 keymap decoder: scancodes, action indices,
// prefix FSM encoding, default two-player keymap and the parity helper.
package ps2_keymap_decoder_pkg;

  // Prefix and key scancodes (set 2)
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Action indices inside one player's 5-bit group
  localparam int ACT_UP      = 0;
  localparam int ACT_DOWN    = 1;
  localparam int ACT_LEFT    = 2;
  localparam int ACT_RIGHT   = 3;
  localparam int ACT_FIRE    = 4;
  localparam int NUM_ACTIONS = 5;

  // Keymap entry width: {ext, code}
  localparam int KEY_W = 9;

  // "No direction remembered" marker for the exclusive resolver
  localparam logic [2:0] DIR_NONE = 3'd4;

  // Prefix tracker states
  typedef enum logic [1:0] {
    PFX_IDLE    = 2'd0,
    PFX_EXT     = 2'd1,
    PFX_BRK     = 2'd2,
    PFX_EXT_BRK = 2'd3
  } pfx_state_t;

  // Default map, MSB entry first: P2 fire,right,left,down,up then P1 fire..up
  localparam logic [89:0] DEFAULT_KEYMAP = {
    1'b0, SC_ENTER, 1'b1, SC_RIGHT, 1'b1, SC_LEFT, 1'b1, SC_DOWN, 1'b1, SC_UP,
    1'b0, SC_SPACE, 1'b0, SC_D,     1'b0, SC_A,    1'b0, SC_S,    1'b0, SC_W
  };

  // Odd parity holds when data plus parity bit contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
    return ^data_and_parity;
  endfunction

endpackage

// File: rtl/ps2_keymap_decoder_rx.sv
// PS/2 receiver: synchronises and debounces kclk/kdata, frames 11-bit
// packets on filtered kclk falls, checks start/stop/parity and aborts stalled
// frames. Emits registered frame_valid/scancode/frame_err pulses.
module ps2_rx
  import ps2_keymap_decoder_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  output logic       frame_valid,
  output logic [7:0] scancode,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    kclk_sync;
  logic [1:0]    kdata_sync;
  logic          kclk_filt;
  logic          kdata_filt;
  logic          kclk_filt_d;
  logic [FW-1:0] kclk_cnt;
  logic [FW-1:0] kdata_cnt;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;

  logic          fall;
  logic [10:0]   word;
  logic          word_ok;
  logic          timeout;

  // Two-flop synchronisers; idle PS/2 lines are high
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_sync  <= 2'b11;
      kdata_sync <= 2'b11;
    end else begin
      kclk_sync  <= {kclk_sync[0], kclk};
      kdata_sync <= {kdata_sync[0], kdata};
    end
  end

  // Debounce: a filtered line follows only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_filt   <= 1'b1;
      kdata_filt  <= 1'b1;
      kclk_cnt    <= {FW{1'b0}};
      kdata_cnt   <= {FW{1'b0}};
      kclk_filt_d <= 1'b1;
    end else begin
      kclk_filt_d <= kclk_filt;
      if (kclk_sync[1] == kclk_filt) begin
        kclk_cnt <= {FW{1'b0}};
      end else if (kclk_cnt == FW'(FILTER_LEN - 1)) begin
        kclk_filt <= kclk_sync[1];
        kclk_cnt  <= {FW{1'b0}};
      end else begin
        kclk_cnt <= kclk_cnt + FW'(1);
      end
      if (kdata_sync[1] == kdata_filt) begin
        kdata_cnt <= {FW{1'b0}};
      end else if (kdata_cnt == FW'(FILTER_LEN - 1)) begin
        kdata_filt <= kdata_sync[1];
        kdata_cnt  <= {FW{1'b0}};
      end else begin
        kdata_cnt <= kdata_cnt + FW'(1);
      end
    end
  end

  // Falling edge, completed word and frame checks
  always_comb begin
    fall    = kclk_filt_d & ~kclk_filt;
    word    = {kdata_filt, shreg};
    word_ok = (word[0] == 1'b0) && (word[10] == 1'b1) && odd_parity_ok(word[9:1]);
    timeout = (bit_cnt != 4'd0) && (timer == TW'(TIMEOUT_CYC - 1));
  end

  // Bit collection, frame completion and stall timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= 4'd0;
      shreg       <= 10'd0;
      timer       <= {TW{1'b0}};
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      scancode    <= 8'h00;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (fall) begin
        timer <= {TW{1'b0}};
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (word_ok) begin
            frame_valid <= 1'b1;
            scancode    <= word[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {kdata_filt, shreg[9:1]};
        end
      end else if (timeout) begin
        bit_cnt   <= 4'd0;
        timer     <= {TW{1'b0}};
        frame_err <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= {TW{1'b0}};
      end
    end
  end

endmodule

// File: rtl/ps2_keymap_decoder.sv
// PS/2 keyboard front end for the tank game: receives bytes, tracks E0/F0
// prefixes, maps key events onto per-player held actions and optionally
// reduces each player's directions to a single active one.
module ps2_keymap_decoder
  import ps2_keymap_decoder_pkg::*;
#(
  parameter int                          NUM_PLAYERS   = 2,
  parameter logic [NUM_PLAYERS*45-1:0]   KEYMAP        = DEFAULT_KEYMAP,
  parameter int                          FILTER_LEN    = 4,
  parameter int                          TIMEOUT_CYC   = 200000,
  parameter int                          DIR_EXCLUSIVE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     kclk,
  input  logic                     kdata,
  output logic [NUM_PLAYERS*5-1:0] act_held,
  output logic [NUM_PLAYERS-1:0]   fire_pulse,
  output logic                     frame_valid,
  output logic [7:0]               scancode,
  output logic                     frame_err
);

  localparam int NA = NUM_PLAYERS * NUM_ACTIONS;

  pfx_state_t                   state;
  pfx_state_t                   state_next;
  logic                         ev_valid;
  logic                         ev_ext;
  logic                         ev_brk;
  logic [NA-1:0]                held;
  logic [NA-1:0]                held_next;
  logic [NA-1:0]                act_next;
  logic [NUM_PLAYERS-1:0]       fire_next;
  logic [NUM_PLAYERS-1:0][2:0]  last_dir;
  logic [NUM_PLAYERS-1:0][2:0]  last_dir_next;
  logic [2:0]                   sel;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .kclk       (kclk),
    .kdata      (kdata),
    .frame_valid(frame_valid),
    .scancode   (scancode),
    .frame_err  (frame_err)
  );

  // Prefix tracker: accumulate E0/F0 flags, emit a key event on any other byte
  always_comb begin
    state_next = state;
    ev_valid   = 1'b0;
    ev_ext     = 1'b0;
    ev_brk     = 1'b0;
    if (frame_err) begin
      state_next = PFX_IDLE;
    end else if (frame_valid) begin
      case (state)
        PFX_IDLE: begin
          if (scancode == SC_E0) begin
            state_next = PFX_EXT;
          end else if (scancode == SC_F0) begin
            state_next = PFX_BRK;
          end else begin
            ev_valid   = 1'b1;
            state_next = PFX_IDLE;
          end
        end
        PFX_EXT: begin
          if (scancode == SC_E0) begin
            state_next = PFX_EXT;
          end else if (scancode == SC_F0) begin
            state_next = PFX_EXT_BRK;
          end else begin
            ev_valid   = 1'b1;
            ev_ext     = 1'b1;
            state_next = PFX_IDLE;
          end
        end
        PFX_BRK: begin
          if (scancode == SC_E0) begin
            state_next = PFX_EXT_BRK;
          end else if (scancode == SC_F0) begin
            state_next = PFX_BRK;
          end else begin
            ev_valid   = 1'b1;
            ev_brk     = 1'b1;
            state_next = PFX_IDLE;
          end
        end
        PFX_EXT_BRK: begin
          if ((scancode == SC_E0) || (scancode == SC_F0)) begin
            state_next = PFX_EXT_BRK;
          end else begin
            ev_valid   = 1'b1;
            ev_ext     = 1'b1;
            ev_brk     = 1'b1;
            state_next = PFX_IDLE;
          end
        end
        default: state_next = PFX_IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Keymap match: every matching entry is set on make or cleared on break
  always_comb begin
    held_next     = held;
    last_dir_next = last_dir;
    fire_next     = {NUM_PLAYERS{1'b0}};
    if (ev_valid) begin
      for (int i = 0; i < NA; i++) begin
        if (KEYMAP[i*KEY_W +: KEY_W] == {ev_ext, scancode}) begin
          if (ev_brk) begin
            held_next[i] = 1'b0;
          end else begin
            held_next[i] = 1'b1;
            if ((i % NUM_ACTIONS) == ACT_FIRE) begin
              // Typematic repeats arrive with the bit already set: no pulse
              fire_next[i / NUM_ACTIONS] = fire_next[i / NUM_ACTIONS] | ~held[i];
            end else begin
              last_dir_next[i / NUM_ACTIONS] = 3'(i % NUM_ACTIONS);
            end
          end
        end else begin
          held_next[i] = held_next[i];
        end
      end
    end else begin
      held_next = held;
    end
  end

  // Direction resolver: latest still-held make wins, else lowest held index
  always_comb begin
    act_next = held_next;
    sel      = DIR_NONE;
    if (DIR_EXCLUSIVE != 0) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        sel = DIR_NONE;
        for (int a = ACT_RIGHT; a >= ACT_UP; a--) begin
          if (held_next[p*NUM_ACTIONS + a]) begin
            sel = 3'(a);
          end else begin
            sel = sel;
          end
        end
        if ((last_dir_next[p] != DIR_NONE) &&
            held_next[p*NUM_ACTIONS + int'(last_dir_next[p])]) begin
          sel = last_dir_next[p];
        end else begin
          sel = sel;
        end
        for (int a = ACT_UP; a <= ACT_RIGHT; a++) begin
          act_next[p*NUM_ACTIONS + a] = (sel == 3'(a));
        end
      end
    end else begin
      act_next = held_next;
    end
  end

  // State, held bitmap and registered action outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PFX_IDLE;
      held       <= {NA{1'b0}};
      last_dir   <= {NUM_PLAYERS{DIR_NONE}};
      act_held   <= {NA{1'b0}};
      fire_pulse <= {NUM_PLAYERS{1'b0}};
    end else begin
      state      <= state_next;
      held       <= held_next;
      last_dir   <= last_dir_next;
      act_held   <= act_next;
      fire_pulse <= fire_next;
    end
  end

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Self-checking bench for ps2_keymap_decoder: two instances (exclusive and
// raw direction modes) share one PS/2 line; a flag-based keyboard model
// predicts held actions, fire pulses and frame/error counts.
module tb_ps2_keymap_decoder;

  localparam int HALF = 12;
  localparam int TMO  = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kclk = 1'b1;
  logic       kdata = 1'b1;
  logic [9:0] act_x, act_r;
  logic [1:0] fp_x, fp_r;
  logic       fv_x, fv_r, fe_x, fe_r;
  logic [7:0] sc_x, sc_r;

  always #5 clk = ~clk;

  ps2_keymap_decoder #(.NUM_PLAYERS(2), .FILTER_LEN(4), .TIMEOUT_CYC(TMO), .DIR_EXCLUSIVE(1)) dut_x (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata), .act_held(act_x), .fire_pulse(fp_x),
    .frame_valid(fv_x), .scancode(sc_x), .frame_err(fe_x));

  ps2_keymap_decoder #(.NUM_PLAYERS(2), .FILTER_LEN(4), .TIMEOUT_CYC(TMO), .DIR_EXCLUSIVE(0)) dut_r (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata), .act_held(act_r), .fire_pulse(fp_r),
    .frame_valid(fv_r), .scancode(sc_r), .frame_err(fe_r));

  int checks = 0;
  int failures = 0;

  // Event counters observed on the exclusive instance
  int         fv_cnt = 0;
  int         fe_cnt = 0;
  int         fp_cnt0 = 0;
  int         fp_cnt1 = 0;
  logic       fv_d = 1'b0;
  logic [9:0] act_after_fv = 10'd0;

  always @(negedge clk) begin
    if (fv_x) fv_cnt <= fv_cnt + 1;
    if (fe_x) fe_cnt <= fe_cnt + 1;
    if (fp_x[0]) fp_cnt0 <= fp_cnt0 + 1;
    if (fp_x[1]) fp_cnt1 <= fp_cnt1 + 1;
    fv_d <= fv_x;
    if (fv_d) act_after_fv <= act_x;
  end

  // Keyboard model: keymap table, prefix flags, held keys, expected counts
  logic [8:0] km [10] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h029,
                          9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A};
  logic [9:0] m_held = 10'd0;
  int         m_last [2] = '{-1, -1};
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  int         m_fv = 0;
  int         m_fe = 0;
  int         m_fp0 = 0;
  int         m_fp1 = 0;
  logic [7:0] m_sc = 8'h00;

  function automatic logic [9:0] exp_excl();
    logic [9:0] r;
    int sel;
    r = 10'd0;
    for (int p = 0; p < 2; p++) begin
      sel = -1;
      if (m_last[p] >= 0 && m_held[p*5 + m_last[p]]) sel = m_last[p];
      else for (int a = 0; a < 4; a++) if (sel < 0 && m_held[p*5 + a]) sel = a;
      for (int a = 0; a < 4; a++) r[p*5 + a] = (a == sel);
      r[p*5 + 4] = m_held[p*5 + 4];
    end
    return r;
  endfunction

  task automatic model_byte(input logic [7:0] c, input bit good);
    if (!good) begin
      m_fe++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_fv++;
      m_sc = c;
      if (c == 8'hE0) m_ext = 1'b1;
      else if (c == 8'hF0) m_brk = 1'b1;
      else begin
        for (int i = 0; i < 10; i++) begin
          if (km[i] == {m_ext, c}) begin
            if (m_brk) m_held[i] = 1'b0;
            else begin
              if (i % 5 == 4) begin
                if (!m_held[i]) begin
                  if (i / 5 == 0) m_fp0++; else m_fp1++;
                end
              end else m_last[i / 5] = i % 5;
              m_held[i] = 1'b1;
            end
          end
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_held = 10'd0;
    m_last = '{-1, -1};
    m_ext  = 1'b0;
    m_brk  = 1'b0;
  endtask

  // Drive nbits of an 11-bit frame; optional parity error and kclk glitches
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit glitch, input int nbits);
    logic [10:0] w;
    w = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk);
      kdata = w[b];
      if (glitch) begin
        repeat (4) @(negedge clk);
        kclk = 1'b0;
        @(negedge clk);
        kclk = 1'b1;
        repeat (HALF - 5) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      kclk = 1'b0;
      repeat (HALF) @(negedge clk);
      kclk = 1'b1;
    end
    @(negedge clk);
    kdata = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b0, 11);
    model_byte(code, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (act_x !== 10'd0) begin failures++; $display("FAIL reset_act_x got=%b exp=%b", act_x, 10'd0); end
    checks++; if (act_r !== 10'd0) begin failures++; $display("FAIL reset_act_r got=%b exp=%b", act_r, 10'd0); end
    checks++; if ({fp_x, fv_x, fe_x} !== 4'd0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {fp_x, fv_x, fe_x}); end
    checks++; if (sc_x !== 8'h00) begin failures++; $display("FAIL reset_scancode got=%h exp=00", sc_x); end
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_make_break();
    send(8'h1D);
    checks++; if (fv_cnt !== m_fv) begin failures++; $display("FAIL w_frame_cnt got=%0d exp=%0d", fv_cnt, m_fv); end
    checks++; if (sc_x !== 8'h1D) begin failures++; $display("FAIL w_scancode got=%h exp=1d", sc_x); end
    checks++; if (act_after_fv !== 10'b0000000001) begin failures++; $display("FAIL w_latency got=%b exp=%b", act_after_fv, 10'b1); end
    send(8'hF0); send(8'h1D);
    checks++; if (act_x !== exp_excl()) begin failures++; $display("FAIL w_break got=%b exp=%b", act_x, exp_excl()); end
    checks++; if (act_x[0] !== 1'b0) begin failures++; $display("FAIL w_break_bit got=%b exp=0", act_x[0]); end
  endtask

  task automatic test_extended();
    send(8'hE0); send(8'h75);
    checks++; if (act_x !== exp_excl() || act_x[5] !== 1'b1) begin failures++; $display("FAIL p2_up_make got=%b exp=%b", act_x, exp_excl()); end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if (act_x !== exp_excl() || act_x[5] !== 1'b0) begin failures++; $display("FAIL p2_up_break got=%b exp=%b", act_x, exp_excl()); end
    send(8'h75);
    checks++; if (act_x !== 10'd0) begin failures++; $display("FAIL plain_75 got=%b exp=%b", act_x, 10'd0); end
  endtask

  task automatic test_fire();
    int p0;
    p0 = fp_cnt0;
    send(8'h29); send(8'h29); send(8'h29);
    checks++; if (fp_cnt0 - p0 !== 1) begin failures++; $display("FAIL fire_once got=%0d exp=1", fp_cnt0 - p0); end
    checks++; if (act_x[4] !== 1'b1) begin failures++; $display("FAIL fire_held got=%b exp=1", act_x[4]); end
    send(8'hF0); send(8'h29);
    checks++; if (act_x !== exp_excl()) begin failures++; $display("FAIL fire_break got=%b exp=%b", act_x, exp_excl()); end
    send(8'h29);
    checks++; if (fp_cnt0 !== m_fp0 || fp_cnt0 - p0 !== 2) begin failures++; $display("FAIL fire_again got=%0d exp=%0d", fp_cnt0, m_fp0); end
    send(8'hF0); send(8'h29);
  endtask

  task automatic test_exclusive();
    send(8'h1D); send(8'h1C);
    checks++; if (act_x !== 10'b0000000100) begin failures++; $display("FAIL excl_left got=%b exp=%b", act_x, 10'b100); end
    checks++; if (act_r !== 10'b0000000101) begin failures++; $display("FAIL raw_both got=%b exp=%b", act_r, 10'b101); end
    send(8'hF0); send(8'h1C);
    checks++; if (act_x !== 10'b0000000001) begin failures++; $display("FAIL excl_up got=%b exp=%b", act_x, 10'b1); end
    send(8'hF0); send(8'h1D);
    checks++; if (act_x !== 10'd0 || act_r !== 10'd0) begin failures++; $display("FAIL excl_none got=%b/%b exp=0", act_x, act_r); end
  endtask

  task automatic test_errors();
    send_frame(8'h1D, 1'b1, 1'b0, 11);
    model_byte(8'h1D, 1'b0);
    checks++; if (fe_cnt !== m_fe) begin failures++; $display("FAIL parity_err got=%0d exp=%0d", fe_cnt, m_fe); end
    checks++; if (act_x !== 10'd0 || fv_cnt !== m_fv) begin failures++; $display("FAIL parity_nochange got=%b fv=%0d exp_fv=%0d", act_x, fv_cnt, m_fv); end
    send_frame(8'h1B, 1'b0, 1'b0, 5);
    repeat (TMO + 100) @(negedge clk);
    model_byte(8'h00, 1'b0);
    checks++; if (fe_cnt !== m_fe) begin failures++; $display("FAIL timeout_err got=%0d exp=%0d", fe_cnt, m_fe); end
    send(8'h1B);
    checks++; if (act_x !== 10'b0000000010 || sc_x !== 8'h1B) begin failures++; $display("FAIL after_timeout got=%b sc=%h exp=%b sc=1b", act_x, sc_x, 10'b10); end
    send(8'hF0);
    send_frame(8'h12, 1'b1, 1'b0, 11);
    model_byte(8'h12, 1'b0);
    send(8'h1D);
    checks++; if (act_x !== exp_excl() || act_r !== m_held) begin failures++; $display("FAIL err_clears_prefix got=%b/%b exp=%b/%b", act_x, act_r, exp_excl(), m_held); end
    send(8'hF0); send(8'h1B); send(8'hF0); send(8'h1D);
  endtask

  task automatic test_glitch_and_reset();
    send_frame(8'h23, 1'b0, 1'b1, 11);
    model_byte(8'h23, 1'b1);
    checks++; if (fv_cnt !== m_fv || fe_cnt !== m_fe || act_r !== m_held) begin failures++; $display("FAIL glitch got fv=%0d fe=%0d act=%b exp fv=%0d fe=%0d act=%b", fv_cnt, fe_cnt, act_r, m_fv, m_fe, m_held); end
    send(8'hF0);
    do_reset();
    send(8'h1D);
    checks++; if (act_x !== 10'b0000000001) begin failures++; $display("FAIL rst_prefix got=%b exp=%b", act_x, 10'b1); end
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    do_reset();
    repeat (TMO + 100) @(negedge clk);
    checks++; if (fe_cnt !== m_fe || act_x !== 10'd0) begin failures++; $display("FAIL rst_midframe got fe=%0d act=%b exp fe=%0d act=0", fe_cnt, act_x, m_fe); end
  endtask

  task automatic test_random();
    logic [7:0] pool [18] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74,
                              8'h5A, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'hE1, 8'h14};
    logic [7:0] c;
    bit bad, gl;
    for (int n = 0; n < 70; n++) begin
      c = pool[$urandom_range(0, 17)];
      if ($urandom_range(0, 15) == 0) c = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      gl  = ($urandom_range(0, 3) == 0);
      send_frame(c, bad, gl, 11);
      model_byte(c, !bad);
      checks++; if (act_x !== exp_excl()) begin failures++; $display("FAIL rnd%0d_excl code=%h got=%b exp=%b", n, c, act_x, exp_excl()); end
      checks++; if (act_r !== m_held) begin failures++; $display("FAIL rnd%0d_raw code=%h got=%b exp=%b", n, c, act_r, m_held); end
      checks++; if (fp_cnt0 !== m_fp0 || fp_cnt1 !== m_fp1) begin failures++; $display("FAIL rnd%0d_fire got=%0d,%0d exp=%0d,%0d", n, fp_cnt0, fp_cnt1, m_fp0, m_fp1); end
      checks++; if (fv_cnt !== m_fv || fe_cnt !== m_fe || sc_x !== m_sc) begin failures++; $display("FAIL rnd%0d_frames got fv=%0d fe=%0d sc=%h exp fv=%0d fe=%0d sc=%h", n, fv_cnt, fe_cnt, sc_x, m_fv, m_fe, m_sc); end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_fire();
    test_exclusive();
    test_errors();
    test_glitch_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
